// File: rtl/reg_bank_write_decode_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_write_decode_if
// Description : Write/read bus bundle for the 32-entry register bank. The
//               master drives the write request and both read addresses;
//               the slave returns registered read data and the write decode.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_bank_write_decode_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  reg_write;
    logic [4:0]            write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic [4:0]            read_addr_a;
    logic [4:0]            read_addr_b;
    logic [DATA_WIDTH-1:0] read_data_a;
    logic [DATA_WIDTH-1:0] read_data_b;
    logic [31:0]           write_onehot;

    modport master (
        output reg_write,
        output write_addr,
        output write_data,
        output read_addr_a,
        output read_addr_b,
        input  read_data_a,
        input  read_data_b,
        input  write_onehot
    );

    modport slave (
        input  reg_write,
        input  write_addr,
        input  write_data,
        input  read_addr_a,
        input  read_addr_b,
        output read_data_a,
        output read_data_b,
        output write_onehot
    );
endinterface
`default_nettype wire

// File: rtl/reg_bank_write_decode.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_write_decode
// Description : 32-entry register bank. Decodes the destination index into
//               one-hot write enables (register 0 never enabled), presets the
//               stack pointer on reset and offers two registered read ports
//               with write-to-read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_write_decode #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           SP_INDEX   = 29,
    parameter logic [DATA_WIDTH-1:0] SP_INIT    = DATA_WIDTH'(227)
) (
    input  wire                   clock,
    input  wire                   reset,
    reg_bank_write_decode_if.slave bus
);

    logic [DATA_WIDTH-1:0] r_regs [0:31];
    logic [31:0]           w_en;
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;
    logic [DATA_WIDTH-1:0] r_read_data_a;
    logic [DATA_WIDTH-1:0] r_read_data_b;
    logic [31:0]           r_write_onehot;

    // One-hot write enables; bit 0 stays low so register 0 is never written.
    generate
        for (genvar i = 0; i < 32; i++) begin : g_en
            if (i == 0) begin : g_zero
                assign w_en[i] = 1'b0;
            end else begin : g_dec
                assign w_en[i] = bus.reg_write && (bus.write_addr == 5'(i));
            end
        end
    endgenerate

    // Storage: register 0 is constant zero, SP_INDEX presets to SP_INIT.
    generate
        for (genvar i = 0; i < 32; i++) begin : g_reg
            if (i == 0) begin : g_zero
                always_ff @(posedge clock) begin
                    r_regs[i] <= '0;
                end
            end else begin : g_store
                always_ff @(posedge clock) begin
                    if (!reset) begin
                        r_regs[i] <= (i == SP_INDEX) ? SP_INIT : '0;
                    end else if (w_en[i]) begin
                        r_regs[i] <= bus.write_data;
                    end
                end
            end
        end
    endgenerate

    // Read selection with bypass: a write to the addressed register in the
    // same cycle returns the new data. w_en already excludes address 0.
    always_comb begin
        w_rd_a = r_regs[bus.read_addr_a];
        if (bus.read_addr_a == 5'd0) begin
            w_rd_a = '0;
        end else if (w_en[bus.read_addr_a]) begin
            w_rd_a = bus.write_data;
        end
        w_rd_b = r_regs[bus.read_addr_b];
        if (bus.read_addr_b == 5'd0) begin
            w_rd_b = '0;
        end else if (w_en[bus.read_addr_b]) begin
            w_rd_b = bus.write_data;
        end
    end

    // Registered read ports and write-decode echo, cleared during reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_read_data_a  <= '0;
            r_read_data_b  <= '0;
            r_write_onehot <= '0;
        end else begin
            r_read_data_a  <= w_rd_a;
            r_read_data_b  <= w_rd_b;
            r_write_onehot <= w_en;
        end
    end

    assign bus.read_data_a  = r_read_data_a;
    assign bus.read_data_b  = r_read_data_b;
    assign bus.write_onehot = r_write_onehot;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_write_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank_write_decode
// Description : Directed self-checking bench for reg_bank_write_decode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank_write_decode;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    reg_bank_write_decode_if #(.DATA_WIDTH(32)) bus ();

    reg_bank_write_decode #(
        .DATA_WIDTH (32),
        .SP_INDEX   (29),
        .SP_INIT    (32'd227)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.reg_write   = 1'b0;
        bus.write_addr  = 5'd0;
        bus.write_data  = 32'd0;
        bus.read_addr_a = 5'd0;
        bus.read_addr_b = 5'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        step();
        step();
        n_vec++;
        if (bus.read_data_a !== 32'd0) begin
            n_err++;
            $display("FAIL reset_rda: got %h want %h", bus.read_data_a, 32'd0);
        end
        n_vec++;
        if (bus.write_onehot !== 32'd0) begin
            n_err++;
            $display("FAIL reset_onehot: got %h want %h", bus.write_onehot, 32'd0);
        end
        rst_n = 1'b1;
        bus.read_addr_a = 5'd29;
        bus.read_addr_b = 5'd5;
        step();
        n_vec++;
        if (bus.read_data_a !== 32'd227) begin
            n_err++;
            $display("FAIL reset_sp: got %h want %h", bus.read_data_a, 32'd227);
        end
        n_vec++;
        if (bus.read_data_b !== 32'd0) begin
            n_err++;
            $display("FAIL reset_r5: got %h want %h", bus.read_data_b, 32'd0);
        end
        n_vec++;
        if (bus.write_onehot !== 32'd0) begin
            n_err++;
            $display("FAIL reset_onehot2: got %h want %h", bus.write_onehot, 32'd0);
        end
    endtask

    task automatic test_write_read();
        idle();
        bus.reg_write  = 1'b1;
        bus.write_addr = 5'd8;
        bus.write_data = 32'hDEADBEEF;
        step();
        n_vec++;
        if (bus.write_onehot !== 32'h0000_0100) begin
            n_err++;
            $display("FAIL wr8_onehot: got %h want %h", bus.write_onehot, 32'h100);
        end
        idle();
        bus.read_addr_a = 5'd8;
        step();
        n_vec++;
        if (bus.read_data_a !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL rd8: got %h want %h", bus.read_data_a, 32'hDEADBEEF);
        end
        n_vec++;
        if (bus.write_onehot !== 32'd0) begin
            n_err++;
            $display("FAIL idle_onehot: got %h want %h", bus.write_onehot, 32'd0);
        end
    endtask

    task automatic test_reg0_write();
        idle();
        bus.reg_write  = 1'b1;
        bus.write_addr = 5'd0;
        bus.write_data = 32'h12345678;
        step();
        n_vec++;
        if (bus.read_data_a !== 32'd0) begin
            n_err++;
            $display("FAIL r0_bypass: got %h want %h", bus.read_data_a, 32'd0);
        end
        n_vec++;
        if (bus.write_onehot !== 32'd0) begin
            n_err++;
            $display("FAIL r0_onehot: got %h want %h", bus.write_onehot, 32'd0);
        end
        idle();
        step();
        n_vec++;
        if (bus.read_data_a !== 32'd0) begin
            n_err++;
            $display("FAIL r0_read: got %h want %h", bus.read_data_a, 32'd0);
        end
    endtask

    task automatic test_bypass();
        idle();
        bus.reg_write  = 1'b1;
        bus.write_addr = 5'd3;
        bus.write_data = 32'h11;
        step();
        idle();
        bus.read_addr_a = 5'd3;
        bus.read_addr_b = 5'd3;
        step();
        n_vec++;
        if (bus.read_data_a !== 32'h11) begin
            n_err++;
            $display("FAIL r3_old: got %h want %h", bus.read_data_a, 32'h11);
        end
        bus.reg_write  = 1'b1;
        bus.write_addr = 5'd3;
        bus.write_data = 32'h22;
        step();
        n_vec++;
        if (bus.read_data_a !== 32'h22) begin
            n_err++;
            $display("FAIL byp_a: got %h want %h", bus.read_data_a, 32'h22);
        end
        n_vec++;
        if (bus.read_data_b !== 32'h22) begin
            n_err++;
            $display("FAIL byp_b: got %h want %h", bus.read_data_b, 32'h22);
        end
        n_vec++;
        if (bus.write_onehot !== 32'h8) begin
            n_err++;
            $display("FAIL byp_onehot: got %h want %h", bus.write_onehot, 32'h8);
        end
        bus.reg_write = 1'b0;
        step();
        n_vec++;
        if (bus.read_data_b !== 32'h22) begin
            n_err++;
            $display("FAIL r3_new: got %h want %h", bus.read_data_b, 32'h22);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        bus.reg_write  = 1'b1;
        bus.write_addr = 5'd31;
        bus.write_data = 32'h55;
        step();
        rst_n          = 1'b0;
        bus.write_data = 32'h99;
        bus.read_addr_a = 5'd31;
        bus.read_addr_b = 5'd31;
        step();
        n_vec++;
        if (bus.read_data_a !== 32'd0) begin
            n_err++;
            $display("FAIL rst_wr_rda: got %h want %h", bus.read_data_a, 32'd0);
        end
        n_vec++;
        if (bus.write_onehot !== 32'd0) begin
            n_err++;
            $display("FAIL rst_wr_onehot: got %h want %h", bus.write_onehot, 32'd0);
        end
        rst_n = 1'b1;
        idle();
        bus.read_addr_a = 5'd31;
        bus.read_addr_b = 5'd29;
        step();
        n_vec++;
        if (bus.read_data_a !== 32'd0) begin
            n_err++;
            $display("FAIL rst_r31: got %h want %h", bus.read_data_a, 32'd0);
        end
        n_vec++;
        if (bus.read_data_b !== 32'd227) begin
            n_err++;
            $display("FAIL rst_sp: got %h want %h", bus.read_data_b, 32'd227);
        end
        bus.read_addr_a = 5'd8;
        step();
        n_vec++;
        if (bus.read_data_a !== 32'd0) begin
            n_err++;
            $display("FAIL rst_r8: got %h want %h", bus.read_data_a, 32'd0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_oh;
        idle();
        for (int i = 1; i < 32; i++) begin
            bus.reg_write  = 1'b1;
            bus.write_addr = 5'(i);
            bus.write_data = 32'(i + 100);
            step();
            exp_oh = 32'd1 << i;
            n_vec++;
            if (bus.write_onehot !== exp_oh) begin
                n_err++;
                $display("FAIL sweep_onehot[%0d]: got %h want %h", i, bus.write_onehot, exp_oh);
            end
        end
        idle();
        for (int i = 1; i < 32; i++) begin
            bus.read_addr_a = 5'(i);
            bus.read_addr_b = 5'(32 - i);
            step();
            n_vec++;
            if (bus.read_data_a !== 32'(i + 100)) begin
                n_err++;
                $display("FAIL sweep_a[%0d]: got %h want %h", i, bus.read_data_a, 32'(i + 100));
            end
            n_vec++;
            if (bus.read_data_b !== 32'(132 - i)) begin
                n_err++;
                $display("FAIL sweep_b[%0d]: got %h want %h", i, bus.read_data_b, 32'(132 - i));
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        test_reset();
        test_write_read();
        test_reg0_write();
        test_bypass();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
